adder_word_sequencer: RTL and testbench

Initiator for the full_adder tile's operand/carry interface. It splits a wide addition of up to MAX_WORDS words into WIDTH-bit words and issues them to one full_adder tile, least-significant word first. After each word it waits for the tile's ack, then captures the sum word and carry_out. It feeds that carry back as carry_in, with carry_listen asserted, on the next word. It sits between the tile control logic and one full_adder instance.

---
 rtl/adder_word_sequencer.sv | 156 +++++++++++++++
 tb/tb_adder_word_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_word_sequencer.sv
// Multi-word addition sequencer driving a single full_adder tile, one WIDTH-bit word
// per handshake, least-significant word first, with the carry chained between words.
module adder_word_sequencer #(
   parameter int WIDTH       = 16,
   parameter int MAX_WORDS   = 4,
   parameter int ACK_TIMEOUT = 15,
   parameter int CNT_W       = $clog2(MAX_WORDS + 1)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic [CNT_W-1:0]           num_words,
   input  logic                       cin_first,
   input  logic [WIDTH*MAX_WORDS-1:0] op_a,
   input  logic [WIDTH*MAX_WORDS-1:0] op_b,
   output logic                       busy,
   output logic                       done,
   output logic                       err,
   output logic [WIDTH*MAX_WORDS-1:0] result,
   output logic                       carry_final,
   output logic [WIDTH-1:0]           add_a,
   output logic [WIDTH-1:0]           add_b,
   output logic                       add_carry_in,
   output logic                       add_carry_listen,
   output logic                       add_on_off,
   input  logic [WIDTH-1:0]           add_c,
   input  logic                       add_carry_out,
   input  logic                       add_ack
);

   localparam int OPW = WIDTH * MAX_WORDS;
   localparam int TW  = $clog2(ACK_TIMEOUT + 1);

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT_ACK,
      DONE,
      ERROR
   } state_t;

   state_t state, state_next;

   logic [OPW-1:0]   a_lat, b_lat;
   logic [OPW-1:0]   result_r;
   logic [CNT_W-1:0] n_lat;
   logic [CNT_W-1:0] idx;
   logic             carry_r;
   logic             listen0_r;
   logic             cf_r;
   logic [TW-1:0]    cnt;
   logic [TW-1:0]    cnt_inc;
   logic             accept;
   logic             last_word;

   assign result      = result_r;
   assign carry_final = cf_r;

   always_comb begin
      state_next       = state;
      accept           = 1'b0;
      busy             = 1'b0;
      done             = 1'b0;
      err              = 1'b0;
      add_a            = '0;
      add_b            = '0;
      add_carry_in     = 1'b0;
      add_carry_listen = 1'b0;
      add_on_off       = 1'b0;
      last_word        = (idx == n_lat - CNT_W'(1));
      cnt_inc          = cnt + TW'(1);

      case (state)
         IDLE: begin
            if (start) begin
               if (num_words != '0 && num_words <= CNT_W'(MAX_WORDS)) begin
                  accept     = 1'b1;
                  state_next = ISSUE;
               end else begin
                  state_next = ERROR;
               end
            end
         end
         ISSUE, WAIT_ACK: begin
            // Tile inputs come straight from latched state, so they stay stable across WAIT_ACK.
            busy             = 1'b1;
            add_a            = a_lat[idx*WIDTH +: WIDTH];
            add_b            = b_lat[idx*WIDTH +: WIDTH];
            add_carry_in     = carry_r;
            add_carry_listen = (idx != '0) || listen0_r;
            add_on_off       = 1'b1;
            if (state == ISSUE) begin
               state_next = WAIT_ACK;
            end else if (add_ack) begin
               state_next = last_word ? DONE : ISSUE;
            end else if (cnt_inc == TW'(ACK_TIMEOUT)) begin
               state_next = ERROR;
            end
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         ERROR: begin
            err        = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         a_lat     <= '0;
         b_lat     <= '0;
         n_lat     <= '0;
         idx       <= '0;
         carry_r   <= 1'b0;
         listen0_r <= 1'b0;
         cf_r      <= 1'b0;
         cnt       <= '0;
         result_r  <= '0;
      end else begin
         state <= state_next;
         case (state)
            IDLE: begin
               if (accept) begin
                  a_lat     <= op_a;
                  b_lat     <= op_b;
                  n_lat     <= num_words;
                  carry_r   <= cin_first;
                  listen0_r <= cin_first;
                  idx       <= '0;
                  result_r  <= '0;
                  cf_r      <= 1'b0;
               end
            end
            ISSUE: cnt <= '0;
            WAIT_ACK: begin
               if (add_ack) begin
                  result_r[idx*WIDTH +: WIDTH] <= add_c;
                  carry_r                      <= add_carry_out;
                  // Final carry is captured with the last word so it is valid during DONE.
                  if (last_word) cf_r <= add_carry_out;
                  else           idx  <= idx + CNT_W'(1);
               end else begin
                  cnt <= cnt_inc;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_adder_word_sequencer.sv
// Directed bench for adder_word_sequencer with a behavioural full_adder tile whose ack can be disabled.
module tb_adder_word_sequencer;

   localparam int WIDTH     = 16;
   localparam int MAX_WORDS = 4;
   localparam int CNT_W     = 3;
   localparam int OPW       = WIDTH * MAX_WORDS;

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   logic [CNT_W-1:0] num_words;
   logic             cin_first;
   logic [OPW-1:0]   op_a, op_b;
   logic             busy, done, err;
   logic [OPW-1:0]   result;
   logic             carry_final;
   logic [WIDTH-1:0] add_a, add_b, add_c;
   logic             add_carry_in, add_carry_listen, add_on_off;
   logic             add_carry_out, add_ack;
   logic             ack_en;
   logic [WIDTH:0]   tile_sum;

   int errors = 0;
   int checks = 0;

   logic [WIDTH-1:0] log_a      [0:63];
   logic             log_listen [0:63];
   logic             log_cin    [0:63];

   always #5 clk = ~clk;

   assign tile_sum      = {1'b0, add_a} + {1'b0, add_b}
                        + {{WIDTH{1'b0}}, add_carry_listen & add_carry_in};
   assign add_c         = tile_sum[WIDTH-1:0];
   assign add_carry_out = tile_sum[WIDTH];
   assign add_ack       = add_on_off & ack_en;

   adder_word_sequencer #(
      .WIDTH      (WIDTH),
      .MAX_WORDS  (MAX_WORDS),
      .ACK_TIMEOUT(15),
      .CNT_W      (CNT_W)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .start           (start),
      .num_words       (num_words),
      .cin_first       (cin_first),
      .op_a            (op_a),
      .op_b            (op_b),
      .busy            (busy),
      .done            (done),
      .err             (err),
      .result          (result),
      .carry_final     (carry_final),
      .add_a           (add_a),
      .add_b           (add_b),
      .add_carry_in    (add_carry_in),
      .add_carry_listen(add_carry_listen),
      .add_on_off      (add_on_off),
      .add_c           (add_c),
      .add_carry_out   (add_carry_out),
      .add_ack         (add_ack)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Launches one operation and records per-cycle observations; cycle k is the cycle after edge E+k.
   task automatic run_op(input logic [CNT_W-1:0] n, input logic [OPW-1:0] a, input logic [OPW-1:0] b,
                         input logic cin, input bit poke,
                         output int busy_cyc, output int onoff_cyc, output int done_at, output int err_at);
      num_words = n;
      op_a      = a;
      op_b      = b;
      cin_first = cin;
      start     = 1'b1;
      tick();
      start     = 1'b0;
      busy_cyc  = 0;
      onoff_cyc = 0;
      done_at   = -1;
      err_at    = -1;
      for (int k = 0; k < 64; k++) begin
         log_a[k]      = add_a;
         log_listen[k] = add_carry_listen;
         log_cin[k]    = add_carry_in;
         if (busy)       busy_cyc++;
         if (add_on_off) onoff_cyc++;
         if (done && done_at < 0) done_at = k;
         if (err && err_at < 0)   err_at = k;
         if (poke && k == 1) begin
            start     = 1'b1;
            op_a      = '1;
            op_b      = '1;
            num_words = 3'd1;
            cin_first = 1'b1;
         end
         if (poke && k == 2) start = 1'b0;
         tick();
         if (done_at >= 0 || err_at >= 0) break;
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      tick();
      tick();
      checks++;
      if ({busy, done, err, carry_final, add_on_off, add_carry_listen, add_carry_in} !== 7'b0) begin
         errors++;
         $display("FAIL reset_ctrl got %b required 0000000",
                  {busy, done, err, carry_final, add_on_off, add_carry_listen, add_carry_in});
      end
      checks++;
      if ({result, add_a, add_b} !== '0) begin
         errors++;
         $display("FAIL reset_data got result=%h a=%h b=%h required 0", result, add_a, add_b);
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_n4_pattern;
      int bc, oc, da, ea;
      run_op(3'd4, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 1'b0, 1'b0, bc, oc, da, ea);
      checks++;
      if (result !== 64'h3333_3333_3333_3333) begin
         errors++;
         $display("FAIL n4_result got %h required 3333333333333333", result);
      end
      checks++;
      if (da !== 8) begin errors++; $display("FAIL n4_done_at got %0d required 8", da); end
   endtask

   task automatic test_illegal;
      int bc, oc, da, ea;
      run_op(3'd0, 64'h1, 64'h1, 1'b0, 1'b0, bc, oc, da, ea);
      checks++;
      if (ea !== 0 || da !== -1 || bc !== 0 || oc !== 0) begin
         errors++;
         $display("FAIL illegal_zero got err_at=%0d done_at=%0d busy=%0d onoff=%0d required 0,-1,0,0",
                  ea, da, bc, oc);
      end
      run_op(3'd5, 64'h1, 64'h1, 1'b0, 1'b0, bc, oc, da, ea);
      checks++;
      if (ea !== 0 || da !== -1 || bc !== 0 || oc !== 0) begin
         errors++;
         $display("FAIL illegal_five got err_at=%0d done_at=%0d busy=%0d onoff=%0d required 0,-1,0,0",
                  ea, da, bc, oc);
      end
      checks++;
      if (result !== 64'h3333_3333_3333_3333) begin
         errors++;
         $display("FAIL illegal_result_kept got %h required 3333333333333333", result);
      end
   endtask

   task automatic test_n1;
      int bc, oc, da, ea;
      run_op(3'd1, 64'h1234, 64'h5678, 1'b1, 1'b0, bc, oc, da, ea);
      checks++;
      if (log_a[0] !== 16'h1234 || log_listen[0] !== 1'b1 || log_cin[0] !== 1'b1) begin
         errors++;
         $display("FAIL n1_issue got a=%h listen=%b cin=%b required 1234,1,1", log_a[0], log_listen[0], log_cin[0]);
      end
      checks++;
      if (result !== 64'h0000_0000_0000_68AD || carry_final !== 1'b0) begin
         errors++;
         $display("FAIL n1_result got %h cf=%b required 00000000000068ad cf=0", result, carry_final);
      end
      checks++;
      if (da !== 2 || bc !== 2) begin
         errors++;
         $display("FAIL n1_timing got done_at=%0d busy=%0d required 2,2", da, bc);
      end
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL n1_done_pulse got %b required 0", done); end
   endtask

   task automatic test_n2_carry;
      int bc, oc, da, ea;
      run_op(3'd2, 64'h0001_FFFF, 64'h0000_0001, 1'b0, 1'b0, bc, oc, da, ea);
      checks++;
      if (log_listen[0] !== 1'b0 || log_a[0] !== 16'hFFFF) begin
         errors++;
         $display("FAIL n2_word0 got a=%h listen=%b required ffff,0", log_a[0], log_listen[0]);
      end
      checks++;
      if (log_listen[2] !== 1'b1 || log_cin[2] !== 1'b1 || log_a[2] !== 16'h0001) begin
         errors++;
         $display("FAIL n2_word1 got a=%h listen=%b cin=%b required 0001,1,1", log_a[2], log_listen[2], log_cin[2]);
      end
      checks++;
      if (result !== 64'h0000_0000_0002_0000 || carry_final !== 1'b0 || da !== 4) begin
         errors++;
         $display("FAIL n2_result got %h cf=%b done_at=%0d required 0000000000020000 cf=0 done_at=4",
                  result, carry_final, da);
      end
   endtask

   task automatic test_n4_wrap;
      int bc, oc, da, ea;
      run_op(3'd4, '1, 64'h1, 1'b0, 1'b0, bc, oc, da, ea);
      checks++;
      if (result !== 64'h0 || carry_final !== 1'b1) begin
         errors++;
         $display("FAIL wrap_result got %h cf=%b required 0 cf=1", result, carry_final);
      end
      checks++;
      if (oc !== 8) begin errors++; $display("FAIL wrap_onoff got %0d required 8", oc); end
   endtask

   task automatic test_timeout;
      int bc, oc, da, ea;
      ack_en = 1'b0;
      run_op(3'd2, 64'h5, 64'h6, 1'b0, 1'b0, bc, oc, da, ea);
      checks++;
      if (ea !== 16 || da !== -1) begin
         errors++;
         $display("FAIL timeout_err got err_at=%0d done_at=%0d required 16,-1", ea, da);
      end
      checks++;
      if (bc !== 16) begin errors++; $display("FAIL timeout_busy got %0d required 16", bc); end
      checks++;
      if (add_on_off !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
         errors++;
         $display("FAIL timeout_idle got onoff=%b busy=%b err=%b required 0,0,0", add_on_off, busy, err);
      end
      ack_en = 1'b1;
   endtask

   task automatic test_busy_start;
      int bc, oc, da, ea;
      run_op(3'd3, 64'h0000_7000_8000_9000, 64'h0000_1000_8000_7000, 1'b0, 1'b1, bc, oc, da, ea);
      checks++;
      if (result !== 64'h0000_8001_0001_0000 || carry_final !== 1'b0) begin
         errors++;
         $display("FAIL busy_start_result got %h cf=%b required 0000800100010000 cf=0", result, carry_final);
      end
      checks++;
      if (da !== 6) begin errors++; $display("FAIL busy_start_done_at got %0d required 6", da); end
   endtask

   task automatic test_reset_mid;
      int seen;
      ack_en    = 1'b0;
      num_words = 3'd2;
      op_a      = 64'h7;
      op_b      = 64'h9;
      cin_first = 1'b1;
      start     = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 5; k++) tick();
      checks++;
      if (busy !== 1'b1 || add_on_off !== 1'b1) begin
         errors++;
         $display("FAIL mid_busy got busy=%b onoff=%b required 1,1", busy, add_on_off);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if ({busy, done, err, carry_final, add_on_off, add_carry_listen, add_carry_in} !== 7'b0
          || {result, add_a, add_b} !== '0) begin
         errors++;
         $display("FAIL mid_reset got ctrl=%b result=%h a=%h required 0",
                  {busy, done, err, carry_final, add_on_off, add_carry_listen, add_carry_in}, result, add_a);
      end
      seen = 0;
      for (int k = 0; k < 4; k++) begin
         if (done || err || busy) seen++;
         tick();
      end
      checks++;
      if (seen !== 0) begin errors++; $display("FAIL mid_reset_quiet got %0d active cycles required 0", seen); end
      ack_en = 1'b1;
   endtask

   initial begin
      reset     = 1'b1;
      start     = 1'b0;
      num_words = '0;
      cin_first = 1'b0;
      op_a      = '0;
      op_b      = '0;
      ack_en    = 1'b1;
      test_reset();
      test_n4_pattern();
      test_illegal();
      test_n1();
      test_n2_carry();
      test_n4_wrap();
      test_timeout();
      test_busy_start();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
